lanzones_mem_model: RTL and testbench

LANZONES_MEM_MODEL -- requirements
Module: lanzones_mem_model

---
 rtl/lanzones_mem_pkg.sv | 9 +
 rtl/lanzones_mem_array.sv | 24 ++
 rtl/lanzones_mem_model.sv | 75 +++++++
 tb/tb_lanzones_mem_model.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/lanzones_mem_pkg.sv
// lanzones_mem_pkg: shared FSM type, default parameters and counter width
// for the lanzones memory model.
package lanzones_mem_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 65536;
    localparam int DEF_LATENCY = 1;
    localparam int CNT_W       = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lanzones_mem_array.sv
// lanzones_mem_array: word storage with a byte-strobed synchronous write port
// and a combinational read port.
module lanzones_mem_array
    import lanzones_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strobe,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH-1:0];

    always_ff @(posedge clk)
        for (int b = 0; b < DATA_W / 8; b++)
            if (we && strobe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/lanzones_mem_model.sv
// lanzones_mem_model: single-outstanding memory responder with a fixed
// request-to-response latency and out-of-range error reporting.
module lanzones_mem_model
    import lanzones_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                RRdy,
    input  logic [31:0]         RAddr,
    input  logic                RWEn,
    input  logic [DATA_W-1:0]   RWData,
    input  logic [DATA_W/8-1:0] RWStrobe,
    output logic                RVld,
    output logic [DATA_W-1:0]   RData,
    output logic                RErr
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] data_q, rd;
    logic              err_q, accept, in_range;

    assign accept   = state == IDLE && RRdy;
    // full 32-bit compare so addresses never alias modulo DEPTH
    assign in_range = RAddr < 32'(DEPTH);

    lanzones_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
        .clk    (clk),
        .we     (accept && RWEn && in_range),
        .addr   (RAddr[AW-1:0]),
        .wdata  (RWData),
        .strobe (RWStrobe),
        .rdata  (rd)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (RRdy) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = LATENCY == 1 ? '0 : CNT_W'(LATENCY - 2);
            end
            WAIT: begin
                state_d = cnt == '0 ? RESP : WAIT;
                cnt_d   = cnt == '0 ? cnt : cnt - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                data_q <= in_range && !RWEn ? rd : '0;
                err_q  <= !in_range;
            end
        end

    assign RVld  = state == RESP;
    assign RData = RVld ? data_q : '0;
    assign RErr  = RVld && err_q;
endmodule

// File: tb/tb_lanzones_mem_model.sv
// tb_lanzones_mem_model: five latency variants driven in lockstep, each checked
// every cycle against a timeline model, plus hand-computed literal checks.
module tb_lanzones_mem_model;
    import lanzones_mem_pkg::*;

    logic        clk = 0, rstn = 1, RRdy = 0, RWEn = 0;
    logic [31:0] RAddr = 0, RWData = 0;
    logic [3:0]  RWStrobe = 0;
    int          checks = 0, fails = 0;
    int          n1, n3, n5, n2;

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h, want %h", n, a, x);
        end
    endfunction

    for (genvar i = 0; i < 5; i++) begin : g
        localparam int L = i + 1;
        logic        v, er;
        logic [31:0] d, w;
        logic [31:0] xd = 0, last_d = 0;
        int          nresp = 0, e = 0, re = -10;
        bit          pend = 0, xerr = 0, last_err = 0, ev = 0;
        logic [31:0] mm [bit [31:0]];

        lanzones_mem_model #(.LATENCY(L)) u_dut (
            .clk(clk), .rstn(rstn), .RRdy(RRdy), .RAddr(RAddr), .RWEn(RWEn),
            .RWData(RWData), .RWStrobe(RWStrobe), .RVld(v), .RData(d), .RErr(er)
        );

        initial begin
            u_dut.u_array.mem[16] = 32'hDEADBEEF;
            u_dut.u_array.mem[0]  = 32'hCAFEF00D;
            u_dut.u_array.mem[48] = 32'h55555555;
            mm[16] = 32'hDEADBEEF;
            mm[0]  = 32'hCAFEF00D;
            mm[48] = 32'h55555555;
        end

        // model: a request is taken when the previous response has fully ended;
        // its response appears L cycles after acceptance
        always @(posedge clk) begin
            e++;
            if (!rstn) pend = 0;
            else if (RRdy && (!pend || e >= re + 2)) begin
                pend = 1;
                re   = e + L - 1;
                xerr = RAddr >= 32'h10000;
                w    = mm.exists(RAddr) ? mm[RAddr] : 'x;
                xd   = (xerr || RWEn) ? 32'h0 : w;
                if (!xerr && RWEn) begin
                    for (int b = 0; b < 4; b++)
                        if (RWStrobe[b]) w[b*8 +: 8] = RWData[b*8 +: 8];
                    mm[RAddr] = w;
                end
            end
        end

        always @(negedge clk) begin
            ev = rstn && pend && e == re;
            chk($sformatf("L%0d rvld", L), 32'(v), 32'(ev));
            chk($sformatf("L%0d rerr", L), 32'(er), 32'(ev && xerr));
            chk($sformatf("L%0d rdata", L), d, ev ? xd : 32'h0);
            if (v === 1'b1) begin
                nresp++;
                last_d   = d;
                last_err = er;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic we, input logic [31:0] dat, input logic [3:0] s);
        RAddr = a; RWEn = we; RWData = dat; RWStrobe = s; RRdy = 1;
        @(posedge clk);
        #1;
        RRdy = 0; RAddr = 32'h10; RWEn = 1; RWData = $urandom; RWStrobe = 4'hF;
        idle(8);
    endtask

    initial begin
        #1 rstn = 0;
        #1 chk("rst_async_state", 32'(g[4].u_dut.state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 32'(g[3].u_dut.cnt), 32'h0);
        chk("rst_rdata", g[0].d, 32'h0);
        @(posedge clk);
        #1 rstn = 1;

        RAddr = 32'h10; RWEn = 0; RRdy = 1;
        @(posedge clk);
        #1 RRdy = 0;
        @(negedge clk);
        chk("l1_rvld", 32'(g[0].v), 32'h1);
        chk("l1_rdata", g[0].d, 32'hDEADBEEF);
        chk("l1_rerr", 32'(g[0].er), 32'h0);
        @(negedge clk);
        chk("l1_rvld_after", 32'(g[0].v), 32'h0);
        chk("l1_rdata_after", g[0].d, 32'h0);
        idle(8);

        req(32'h20, 1, 32'h11223344, 4'hF);
        req(32'h20, 1, 32'h000000AA, 4'h1);
        req(32'h20, 0, 32'h0, 4'h0);
        chk("l4_merge", g[3].last_d, 32'h112233AA);
        chk("l1_merge", g[0].last_d, 32'h112233AA);

        req(32'h10000, 0, 32'h0, 4'hF);
        chk("oor_err", 32'(g[0].last_err), 32'h1);
        chk("oor_data", g[0].last_d, 32'h0);
        req(32'h10000, 1, 32'h12345678, 4'hF);
        chk("oor_wr_err", 32'(g[2].last_err), 32'h1);
        chk("oor_no_wrap", g[0].u_dut.u_array.mem[0], 32'hCAFEF00D);
        req(32'h10010, 0, 32'h0, 4'hF);
        chk("oor_hi_err", 32'(g[1].last_err), 32'h1);

        n2 = g[1].nresp;
        req(32'h30, 1, 32'h0, 4'h0);
        chk("strb0_resp", 32'(g[1].nresp), 32'(n2 + 1));
        chk("strb0_mem", g[1].u_dut.u_array.mem[48], 32'h55555555);
        req(32'h30, 0, 32'h0, 4'h0);
        chk("strb0_read", g[1].last_d, 32'h55555555);

        n1 = g[0].nresp; n3 = g[2].nresp; n5 = g[4].nresp;
        RAddr = 32'h10; RWEn = 0; RRdy = 1;
        repeat (12) @(posedge clk);
        #1 RRdy = 0;
        idle(10);
        chk("burst_l1", 32'(g[0].nresp - n1), 32'd6);
        chk("burst_l3", 32'(g[2].nresp - n3), 32'd3);
        chk("burst_l5", 32'(g[4].nresp - n5), 32'd2);

        n5 = g[4].nresp;
        RAddr = 32'h10; RWEn = 0; RRdy = 1;
        @(posedge clk);
        #1 RRdy = 0;
        @(posedge clk);
        #1 rstn = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        chk("abort_state", 32'(g[4].u_dut.state), 32'(IDLE));
        idle(6);
        chk("abort_no_resp", 32'(g[4].nresp), 32'(n5));

        RRdy = 1;
        @(posedge clk);
        #1 RRdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("l5_early", 32'(g[4].v), 32'h0);
        end
        @(negedge clk);
        chk("l5_rvld", 32'(g[4].v), 32'h1);
        chk("l5_rdata", g[4].d, 32'hDEADBEEF);
        idle(8);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
